// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_pkg
// Description : Shared types, defaults and helpers for the TDM demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_demux_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_WIDTH    = 1;

    // Bit offset of a slot inside a packed frame
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage : tdm_demux_pkg
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_counter
// Description : Slot select counter with clear / load-to-1 / increment.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_counter #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last
);

    logic [SEL_W-1:0] r_sel;

    // CHANNELS is a power of two, so increment wraps to 0 after the last slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
        end else if (i_clr) begin
            r_sel <= '0;
        end else if (i_load1) begin
            r_sel <= SEL_W'(1);
        end else if (i_inc) begin
            r_sel <= r_sel + 1'b1;
        end
    end

    assign o_sel  = r_sel;
    assign o_last = (r_sel == SEL_W'(CHANNELS - 1));

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8
// Description : 1-to-8 TDM demultiplexer with frame-marker alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          dataIn,
    input  logic                      inValid,
    input  logic                      frameStart,
    output logic [CHANNELS*WIDTH-1:0] dataOut,
    output logic                      outValid,
    output logic [SEL_W-1:0]          selectLine,
    output logic                      syncErr,
    output logic                      locked,
    output logic [CNT_W-1:0]          frameCnt
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic [CHANNELS*WIDTH-1:0] r_data_out;
    logic                      r_out_valid;
    logic                      r_sync_err;
    logic [CNT_W-1:0]          r_frame_cnt;

    logic [SEL_W-1:0]          w_sel;
    logic                      w_last;
    logic                      w_sel_zero;
    logic [SEL_W-1:0]          w_wr_idx;
    logic                      w_ctr_clr;
    logic                      w_ctr_load1;
    logic                      w_ctr_inc;
    logic                      w_shadow_we;
    logic                      w_publish;
    logic                      w_sync_err;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_ctr_clr),
        .i_load1 (w_ctr_load1),
        .i_inc   (w_ctr_inc),
        .o_sel   (w_sel),
        .o_last  (w_last)
    );

    assign w_sel_zero = (w_sel == '0);
    assign w_wr_idx   = frameStart ? '0 : w_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (inValid) begin
            case (r_state)
                HUNT:    if (frameStart) w_state_nxt = COLLECT;
                COLLECT: if (!frameStart && w_sel_zero) w_state_nxt = HUNT;
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // An early marker restarts the frame in place rather than dropping lock
    always_comb begin
        w_ctr_clr   = 1'b0;
        w_ctr_load1 = 1'b0;
        w_ctr_inc   = 1'b0;
        w_shadow_we = 1'b0;
        w_publish   = 1'b0;
        w_sync_err  = 1'b0;
        if (inValid) begin
            case (r_state)
                HUNT: begin
                    if (frameStart) begin
                        w_ctr_load1 = 1'b1;
                        w_shadow_we = 1'b1;
                    end
                end
                COLLECT: begin
                    if (frameStart) begin
                        w_ctr_load1 = 1'b1;
                        w_shadow_we = 1'b1;
                        w_sync_err  = !w_sel_zero;
                    end else if (w_sel_zero) begin
                        w_sync_err  = 1'b1;
                        w_ctr_clr   = 1'b1;
                    end else if (w_last) begin
                        w_publish   = 1'b1;
                        w_ctr_inc   = 1'b1;
                    end else begin
                        w_shadow_we = 1'b1;
                        w_ctr_inc   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow    <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_out_valid <= w_publish;
            r_sync_err  <= w_sync_err;
            if (w_shadow_we) begin
                r_shadow[slot_lsb(int'(w_wr_idx), WIDTH) +: WIDTH] <= dataIn;
            end
            if (w_publish) begin
                r_data_out  <= {dataIn, r_shadow[(CHANNELS-1)*WIDTH-1:0]};
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign dataOut    = r_data_out;
    assign outValid   = r_out_valid;
    assign selectLine = w_sel;
    assign syncErr    = r_sync_err;
    assign locked     = (r_state == COLLECT);
    assign frameCnt   = r_frame_cnt;

endmodule : tdm_demux8
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux8
// Description : Self-checking bench for tdm_demux8 (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dataIn = 1'b0;
    logic       inValid = 1'b0;
    logic       frameStart = 1'b0;
    logic [7:0] dataOut;
    logic       outValid;
    logic [2:0] selectLine;
    logic       syncErr;
    logic       locked;
    logic [7:0] frameCnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       v;
        logic       fs;
        logic       d;
        logic [7:0] out;
        logic       ov;
        logic       se;
        logic       lk;
        logic [2:0] sel;
        logic [7:0] cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    tdm_demux8 #(
        .WIDTH    (1),
        .CHANNELS (8),
        .SEL_W    (3),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .inValid    (inValid),
        .frameStart (frameStart),
        .dataOut    (dataOut),
        .outValid   (outValid),
        .selectLine (selectLine),
        .syncErr    (syncErr),
        .locked     (locked),
        .frameCnt   (frameCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cyc(input logic v, input logic fs, input logic d);
        inValid    = v;
        frameStart = fs;
        dataIn     = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset      = 1'b1;
        inValid    = 1'b0;
        frameStart = 1'b0;
        dataIn     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] val);
        for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, val[k]);
    endtask

    function automatic vec_t mk(input logic v, input logic fs, input logic d,
                                input logic [7:0] out, input logic ov, input logic se,
                                input logic lk, input logic [2:0] sel, input logic [7:0] cnt);
        vec_t r;
        r.v = v; r.fs = fs; r.d = d; r.out = out; r.ov = ov;
        r.se = se; r.lk = lk; r.sel = sel; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        logic [7:0] fr [3];
        logic [7:0] gap_val;
        int         cycle;
        int         last_pulse;
        int         npulse;

        //                v  fs d  out    ov se lk sel cnt
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 8'h00, 0, 0, 1, 1, 0);
        vecs[2]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 2, 0);
        vecs[3]  = mk(1, 0, 1, 8'h00, 0, 0, 1, 3, 0);
        vecs[4]  = mk(1, 0, 1, 8'h00, 0, 0, 1, 4, 0);
        vecs[5]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 5, 0);
        vecs[6]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 6, 0);
        vecs[7]  = mk(1, 0, 1, 8'h00, 0, 0, 1, 7, 0);
        vecs[8]  = mk(1, 0, 0, 8'h4D, 1, 0, 1, 0, 1);
        vecs[9]  = mk(0, 0, 0, 8'h4D, 0, 0, 1, 0, 1);
        vecs[10] = mk(1, 1, 1, 8'h4D, 0, 0, 1, 1, 1);
        vecs[11] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 2, 1);
        vecs[12] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 3, 1);
        vecs[13] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 4, 1);
        vecs[14] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 5, 1);
        vecs[15] = mk(1, 1, 0, 8'h4D, 0, 1, 1, 1, 1);
        vecs[16] = mk(1, 0, 0, 8'h4D, 0, 0, 1, 2, 1);
        vecs[17] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 3, 1);
        vecs[18] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 4, 1);
        vecs[19] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 5, 1);
        vecs[20] = mk(1, 0, 1, 8'h4D, 0, 0, 1, 6, 1);
        vecs[21] = mk(1, 0, 0, 8'h4D, 0, 0, 1, 7, 1);
        vecs[22] = mk(1, 0, 0, 8'h3C, 1, 0, 1, 0, 2);
        vecs[23] = mk(0, 0, 0, 8'h3C, 0, 0, 1, 0, 2);
        vecs[24] = mk(1, 0, 1, 8'h3C, 0, 1, 0, 0, 2);
        vecs[25] = mk(1, 0, 1, 8'h3C, 0, 0, 0, 0, 2);
        vecs[26] = mk(0, 0, 0, 8'h3C, 0, 0, 0, 0, 2);

        reset_dut();
        for (int i = 0; i < NV; i++) begin
            if (i == 0) @(negedge clk);
            else cyc(vecs[i].v, vecs[i].fs, vecs[i].d);
            check($sformatf("vec[%0d] {out,ov,se,lk,sel,cnt}", i),
                  {10'd0, dataOut, outValid, syncErr, locked, selectLine, frameCnt},
                  {10'd0, vecs[i].out, vecs[i].ov, vecs[i].se, vecs[i].lk, vecs[i].sel, vecs[i].cnt});
        end

        // Same frame with idle gaps of 1..3 cycles between slots
        reset_dut();
        gap_val = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, k == 0, gap_val[k]);
            if (k < 7) begin
                for (int g = 0; g < (k % 3) + 1; g++) begin
                    cyc(1'b0, 1'b0, 1'b1);
                    check($sformatf("gap sel k=%0d g=%0d", k, g), 32'(selectLine), 32'(k + 1));
                    check($sformatf("gap ov k=%0d g=%0d", k, g), 32'(outValid), 32'd0);
                end
            end
        end
        check("gap ov", 32'(outValid), 32'd1);
        check("gap dataOut", 32'(dataOut), 32'h4D);

        // Three back-to-back frames
        reset_dut();
        fr[0] = 8'hA5; fr[1] = 8'h3C; fr[2] = 8'hFF;
        cycle = 0; last_pulse = 0; npulse = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                cyc(1'b1, k == 0, fr[f][k]);
                cycle++;
                check($sformatf("b2b ov f=%0d k=%0d", f, k), 32'(outValid), 32'(k == 7));
                if (outValid && npulse < 3) begin
                    check($sformatf("b2b dataOut #%0d", npulse), 32'(dataOut), 32'(fr[npulse]));
                    if (npulse > 0)
                        check($sformatf("b2b spacing #%0d", npulse), 32'(cycle - last_pulse), 32'd8);
                    last_pulse = cycle;
                    npulse++;
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("b2b pulses", 32'(npulse), 32'd3);
        check("b2b frameCnt", 32'(frameCnt), 32'd3);
        check("b2b ov after", 32'(outValid), 32'd0);

        // No marker after reset, then asynchronous reset mid-frame
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            check($sformatf("hunt ov/lk/se k=%0d", k), {29'd0, outValid, locked, syncErr}, 32'd0);
        end
        check("hunt sel", 32'(selectLine), 32'd0);
        send_frame(8'hA5);
        check("pre-reset dataOut", 32'(dataOut), 32'hA5);
        cyc(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 4; k++) cyc(1'b1, 1'b0, 1'b1);
        check("pre-reset sel", 32'(selectLine), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("async rst dataOut", 32'(dataOut), 32'd0);
        check("async rst sel", 32'(selectLine), 32'd0);
        check("async rst ov/lk/se", {29'd0, outValid, locked, syncErr}, 32'd0);
        check("async rst frameCnt", 32'(frameCnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Frame counter wrap
        reset_dut();
        repeat (255) send_frame(8'h5A);
        check("frameCnt 255", 32'(frameCnt), 32'd255);
        send_frame(8'h5A);
        check("frameCnt wrap", 32'(frameCnt), 32'd0);
        check("wrap ov", 32'(outValid), 32'd1);
        check("wrap dataOut", 32'(dataOut), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tdm_demux8
`default_nettype wire
